// File: rtl/mnist_rom_pkg.sv
// Shared constants and FSM encoding for the MNIST test-image fetch path.
package mnist_rom_pkg;
    localparam int IMG_PIXELS = 784;
    localparam int NUM_IMAGES = 10;
    localparam int PIX_W      = 10;

    typedef enum logic [1:0] {IDLE, BASE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO that lands ROM read data and holds it under downstream backpressure.
module fetch_skid_buf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [1:0]            occ
);
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    assign pop_data = mem[rd_ptr];

    // Push and pop together at occupancy 2 is safe: the slot being written is the one read out this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/mnist_image_fetch_ctrl.sv
// Streams one MNIST image from the single-port test ROM to the CNN input layer,
// hiding the ROM's one-cycle read latency behind a two-entry buffer.
module mnist_image_fetch_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int IMG_PIXELS = mnist_rom_pkg::IMG_PIXELS,
    parameter int NUM_IMAGES = mnist_rom_pkg::NUM_IMAGES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          img_idx,
    input  logic                           abort,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [ADDR_WIDTH-1:0]          rom_addr,
    input  logic [DATA_WIDTH-1:0]          rom_q,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_last,
    output logic [mnist_rom_pkg::PIX_W-1:0] m_pix
);
    import mnist_rom_pkg::*;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] base;
    logic [PIX_W-1:0]      iss_cnt_q;
    logic [PIX_W-1:0]      pix_q;
    logic                  in_flight_q;
    logic                  done_q;
    logic                  err_q;
    logic [1:0]            occ;
    logic [2:0]            credit;
    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic                  final_xfer;
    logic                  start_ok;
    logic                  start_bad;

    // Stream handshake: a word moves when m_valid & m_ready at a rising edge; while m_valid
    // is high and m_ready low, m_data/m_pix/m_last hold and m_valid stays high.
    assign pop        = m_valid & m_ready;
    assign final_xfer = pop & m_last;
    assign base       = idx_q * ADDR_WIDTH'(IMG_PIXELS);

    // A read is issued only when its data is certain to find a free buffer slot.
    assign credit     = 3'(occ) + 3'(in_flight_q) - 3'(pop);
    assign issue      = (state_q == FETCH) && (credit < 3'd2);
    assign last_issue = issue && (iss_cnt_q == PIX_W'(IMG_PIXELS - 1));

    assign start_ok   = (state_q == IDLE) && start && !abort && (img_idx <  ADDR_WIDTH'(NUM_IMAGES));
    assign start_bad  = (state_q == IDLE) && start && !abort && (img_idx >= ADDR_WIDTH'(NUM_IMAGES));

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign rom_addr = rd_addr_q;
    assign m_valid  = (occ != 2'd0);
    assign m_pix    = pix_q;
    assign m_last   = m_valid && (pix_q == PIX_W'(IMG_PIXELS - 1));

    fetch_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (in_flight_q),
        .push_data (rom_q),
        .pop       (pop),
        .pop_data  (m_data),
        .occ       (occ)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok)   state_d = BASE;
            BASE:                    state_d = FETCH;
            FETCH:   if (last_issue) state_d = DRAIN;
            DRAIN:   if (final_xfer) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            rd_addr_q   <= '0;
            iss_cnt_q   <= '0;
            pix_q       <= '0;
            in_flight_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (abort) begin
            iss_cnt_q   <= '0;
            pix_q       <= '0;
            in_flight_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q      <= (state_q == DRAIN) && final_xfer;
            err_q       <= start_bad;
            in_flight_q <= issue;
            if (start_ok) idx_q <= img_idx;
            // The address stops on the last pixel so it never leaves the image window.
            if (state_q == BASE)
                rd_addr_q <= base;
            else if (issue && !last_issue)
                rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
            if (issue)
                iss_cnt_q <= last_issue ? '0 : iss_cnt_q + PIX_W'(1);
            if (pop)
                pix_q <= m_last ? '0 : pix_q + PIX_W'(1);
        end
    end
endmodule
